// File: rtl/game_flow_ctrl.sv
// Game round sequencer (IDLE/PLAYING/PAUSED/OVER) with Avalon-MM slave, tick divider and round timer.
// Define GAME_FLOW_IRQ_EN to build the irq_pend flag and the irq output.
module game_flow_ctrl #(
  parameter int unsigned TICK_DIV    = 833333,
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        collision_in,
  output logic        game_active,
  output logic        tick,
  output logic        endgg,
  output logic        irq
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] EL_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [DIV_W-1:0]     div, div_nx;
  logic [TIMER_W-1:0]   elapsed, elapsed_nx;
  logic [TIMER_W-1:0]   limit, limit_nx;
  logic [TIMER_W:0]     el_inc;
  logic [31:0]          readdata_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                 sync_dly, coll_edge;
  logic                 irq_pend;
  logic                 wr_en, cmd_start, cmd_pause, cmd_resume, cmd_abort;
  logic                 tick_now, lim_hit, end_ev, abort_acc, start_acc;
  logic                 unused_wd;

  assign unused_wd  = ^writedata;
  assign wr_en      = chipselect & ~write_n;
  assign cmd_start  = wr_en && (address == 2'd1) && writedata[0];
  assign cmd_pause  = wr_en && (address == 2'd1) && writedata[1];
  assign cmd_resume = wr_en && (address == 2'd1) && writedata[2];
  assign cmd_abort  = wr_en && (address == 2'd1) && writedata[3];

  // A tick is the last divider count while PLAYING; the limit check uses one extra bit so a saturated count never matches.
  assign tick_now  = (state == PLAYING) && (div == DIV_LAST);
  assign el_inc    = {1'b0, elapsed} + (TIMER_W+1)'(1);
  assign lim_hit   = tick_now && (limit != '0) && (el_inc == {1'b0, limit});
  assign end_ev    = (state == PLAYING) && (lim_hit || coll_edge);
  assign abort_acc = cmd_abort && (state != IDLE);
  assign start_acc = cmd_start && !abort_acc && !end_ev;

  always_comb begin
    state_nx    = state;
    div_nx      = div;
    elapsed_nx  = elapsed;
    limit_nx    = limit;
    readdata_nx = '0;

    // Priority: ABORT > end event > START > PAUSE > RESUME
    if (abort_acc)                              state_nx = IDLE;
    else if (end_ev)                            state_nx = OVER;
    else if (cmd_start)                         state_nx = PLAYING;
    else if (cmd_pause && state == PLAYING)     state_nx = PAUSED;
    else if (cmd_resume && state == PAUSED)     state_nx = PLAYING;

    // Divider always wraps on a tick so a tick is never counted twice across a pause.
    if (abort_acc || start_acc)                          div_nx = '0;
    else if (tick_now)                                   div_nx = '0;
    else if (state == PLAYING && state_nx == PLAYING)    div_nx = div + 1'b1;

    if (abort_acc || start_acc)   elapsed_nx = '0;
    else if (tick_now) begin
      if (lim_hit)                elapsed_nx = limit;
      else if (elapsed != EL_MAX) elapsed_nx = elapsed + 1'b1;
    end

    if (wr_en && address == 2'd2) limit_nx = writedata[TIMER_W-1:0];

    case (address)
      2'd0:    readdata_nx = 32'({irq_pend, (state == OVER), state});
      2'd2:    readdata_nx = 32'(limit);
      2'd3:    readdata_nx = 32'(elapsed);
      default: readdata_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      div         <= '0;
      elapsed     <= '0;
      limit       <= '0;
      readdata    <= '0;
      sync        <= '0;
      sync_dly    <= 1'b0;
      coll_edge   <= 1'b0;
      tick        <= 1'b0;
      game_active <= 1'b0;
      endgg       <= 1'b0;
    end else begin
      state       <= state_nx;
      div         <= div_nx;
      elapsed     <= elapsed_nx;
      limit       <= limit_nx;
      readdata    <= readdata_nx;
      sync        <= {sync[SYNC_STAGES-2:0], collision_in};
      sync_dly    <= sync[SYNC_STAGES-1];
      coll_edge   <= sync[SYNC_STAGES-1] & ~sync_dly;
      // Flags are computed from next-state values so each equals its state decode without glitches.
      tick        <= (state_nx == PLAYING) && (div_nx == DIV_LAST);
      game_active <= (state_nx == PLAYING);
      endgg       <= (state_nx == OVER);
    end
  end

`ifdef GAME_FLOW_IRQ_EN
  logic irq_pend_nx;
  logic irq_clr;

  assign irq_clr = wr_en && (address == 2'd3) && writedata[0];

  // Entry to OVER wins over a same-cycle clear.
  always_comb begin
    irq_pend_nx = irq_pend;
    if (state_nx == OVER && state != OVER) irq_pend_nx = 1'b1;
    else if (abort_acc || irq_clr)         irq_pend_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_pend <= irq_pend_nx;
      irq      <= irq_pend_nx;
    end
  end
`else
  assign irq_pend = 1'b0;
  assign irq      = 1'b0;
`endif

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Avalon-MM slave that sequences a game round: IDLE, PLAYING, PAUSED, OVER.
- Sits between the Nios II software and the game datapath. Generates the game tick and round timer, synchronises the hardware end-of-game event, and drives the endgg level consumed by the 1-bit end-game PIO.
- Software issues commands; hardware events (collision, time limit) end the round.

Parameters:
TICK_DIV, 833333, clk cycles per game tick (60 Hz at 50 MHz); legal range >=2
TIMER_W, 16, width of elapsed and limit counters
SYNC_STAGES, 2, synchroniser flops on collision_in; legal range >=2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
collision_in  in  1  asynchronous end-of-game request from game logic; level, rising edge significant
game_active  out  1  high when state==PLAYING
tick  out  1  one-cycle pulse per game tick, PLAYING only
endgg  out  1  high when state==OVER; feeds end-game PIO in_port
irq  out  1  interrupt request, level

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset: state=IDLE; divider, elapsed, limit, irq_pend, sync chain and readdata are all 0; tick=0, endgg=0, game_active=0, irq=0.
- State encoding, readable: IDLE=0, PLAYING=1, PAUSED=2, OVER=3.
- Register map (write when chipselect & ~write_n):
  - addr0 STATUS, RO: [1:0] state, [2] endgg, [3] irq_pend, rest 0.
  - addr1 COMMAND, WO, reads 0: [0] START, [1] PAUSE, [2] RESUME, [3] ABORT.
  - addr2 LIMIT, RW: [TIMER_W-1:0] round length in ticks; 0 = unlimited.
  - addr3 ELAPSED: read returns [TIMER_W-1:0] elapsed ticks; write with bit0=1 clears irq_pend.
- Readdata: updated every clk with the mux of the current address, regardless of read strobe. 1-cycle latency.
- Commands: take effect at the clock edge of the write; new state is visible the next cycle.
- Priority within one cycle: ABORT > end event > START > PAUSE > RESUME. Lower-priority commands are dropped, not queued.
- Transitions:
  - IDLE: START -> PLAYING.
  - PLAYING: PAUSE -> PAUSED; ABORT -> IDLE; end event -> OVER; START -> PLAYING (restart).
  - PAUSED: RESUME -> PLAYING; ABORT -> IDLE; START -> PLAYING (restart).
  - OVER: START -> PLAYING; ABORT -> IDLE.
  - Commands not listed for a state are ignored.
- START (any accepted): clears divider and elapsed.
- ABORT: clears irq_pend, divider and elapsed.
- Divider:
  - Counts 0..TICK_DIV-1 only in PLAYING; holds in PAUSED/OVER.
  - tick=1 in the cycle divider==TICK_DIV-1, then divider wraps to 0.
- Elapsed:
  - Increments on tick, saturates at 2^TIMER_W-1.
  - If LIMIT!=0 and tick and elapsed+1==LIMIT: elapsed becomes LIMIT and the end event fires on the same edge.
  - Writing a LIMIT <= current elapsed does not end the round immediately; elapsed continues counting and the round never times out until restarted.
- Collision path:
  - collision_in passes through SYNC_STAGES flops, then a rising-edge detector (one delay flop).
  - The edge acts as an end event only in PLAYING; it is ignored (not remembered) in other states.
  - Latency: OVER is visible SYNC_STAGES+1 clocks after the first edge sampling collision_in high.
- Entry to OVER: sets irq_pend. Clear-irq write and entry to OVER in the same cycle -> set wins.
- endgg = (state==OVER); game_active = (state==PLAYING); both registered/derived from state, glitch-free.
- Reset mid-round: returns immediately to IDLE with all state cleared; no irq.

Optional Feature:
GAME_FLOW_IRQ_EN
- Defined: irq = irq_pend; STATUS[3] reflects irq_pend; ELAPSED write bit0 clears it.
- Undefined: irq_pend logic is not built; irq tied 0; STATUS[3] reads 0; ELAPSED writes have no effect.
- All other behaviour is identical in both builds.

Test Plan:
- TICK_DIV=4, LIMIT=3, write START -> game_active=1 next cycle; tick pulses every 4 clks; after the 3rd tick state=3, endgg=1, ELAPSED=3, irq=1; write addr3=1 -> irq=0.
- PLAYING, raise collision_in and hold -> state=3 exactly SYNC_STAGES+1 clks later; second rising edge while OVER -> no change.
- PLAYING at divider=2, write PAUSE -> tick stops, ELAPSED frozen for 20 clks; write RESUME -> next tick 1 clk later (divider resumed at 2).
- Collision edge and COMMAND=0x1 (START) in same cycle while PLAYING -> state=3. Collision edge and COMMAND=0x8 (ABORT) in same cycle -> state=0, irq=0.
- LIMIT=0, TIMER_W=4 -> ELAPSED saturates at 15; state stays 1.
- Assert reset_n low mid-round with irq=1 -> readdata, irq, endgg, tick all 0 asynchronously; STATUS reads 0 after release.
